// File: rtl/usb_port_reset_sequencer.sv
// USB port attach/reset sequencer: settle, SE0 bus reset, recovery, enable.
// Optional line-state speed latch is built when USB_PORT_SPEED_DETECT_EN is defined.
module usb_port_reset_sequencer #(
    parameter int SETTLE_CYCLES   = 6000000,
    parameter int RESET_CYCLES    = 600000,
    parameter int RECOVERY_CYCLES = 600000,
    parameter int CNT_W           = 24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       device_connected,
    input  logic       disconnect_detected,
    input  logic [1:0] line_state,
    input  logic       bus_reset_req,
    output logic       detector_enable,
    output logic       drive_se0,
    output logic       port_enabled,
    output logic       downstream_reset,
    output logic [1:0] dev_speed,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETTLE   = 3'd1;
    localparam logic [2:0] S_BUS_RST  = 3'd2;
    localparam logic [2:0] S_RECOVERY = 3'd3;
    localparam logic [2:0] S_ENABLED  = 3'd4;

    // The counter reads k-1 in the k-th cycle of a state, so the last cycle is N-1.
    localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVERY_LAST = CNT_W'(RECOVERY_CYCLES - 1);

    localparam logic [1:0] SPEED_FULL = 2'b01;
    localparam logic [1:0] SPEED_LOW  = 2'b00;
    localparam logic [1:0] LINE_K     = 2'b10;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_d;
    logic             det_en_q, det_en_d;
    logic             se0_q, se0_d;
    logic             port_en_q, port_en_d;
    logic             dn_rst_q;
    logic [1:0]       speed_q, speed_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            det_en_q  <= 1'b1;
            se0_q     <= 1'b0;
            port_en_q <= 1'b0;
            dn_rst_q  <= 1'b0;
            speed_q   <= SPEED_FULL;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            det_en_q  <= det_en_d;
            se0_q     <= se0_d;
            port_en_q <= port_en_d;
            dn_rst_q  <= pulse_d;
            speed_q   <= speed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (device_connected) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!device_connected) begin
                    state_d = S_IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_BUS_RST;
                    pulse_d = 1'b1;
                end
            end
            S_BUS_RST: begin
                if (cnt_q == RESET_LAST) begin
                    state_d = S_RECOVERY;
                end
            end
            S_RECOVERY: begin
                if (cnt_q == RECOVERY_LAST) begin
                    if (device_connected) begin
                        state_d = S_ENABLED;
                    end else begin
                        state_d = S_IDLE;
                        pulse_d = 1'b1;
                    end
                end
            end
            S_ENABLED: begin
                // Loss of the device takes priority over a re-reset request.
                if (disconnect_detected || !device_connected) begin
                    state_d = S_IDLE;
                    pulse_d = 1'b1;
                end else if (bus_reset_req) begin
                    state_d = S_BUS_RST;
                    pulse_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (&cnt_q) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Output values are decoded from the next state so they register on the same edge as state.
    always_comb begin
        det_en_d  = (state_d != S_BUS_RST);
        se0_d     = (state_d == S_BUS_RST);
        port_en_d = (state_d == S_ENABLED);
`ifdef USB_PORT_SPEED_DETECT_EN
        speed_d = speed_q;
        if ((state_q == S_SETTLE) && (state_d == S_BUS_RST)) begin
            speed_d = (line_state == LINE_K) ? SPEED_LOW : SPEED_FULL;
        end
`else
        speed_d = SPEED_FULL;
`endif
    end

`ifndef USB_PORT_SPEED_DETECT_EN
    logic unused_line_state;
    assign unused_line_state = ^line_state;
    logic [1:0] unused_speed_low;
    assign unused_speed_low = SPEED_LOW ^ LINE_K;
`endif

    assign state            = state_q;
    assign detector_enable  = det_en_q;
    assign drive_se0        = se0_q;
    assign port_enabled     = port_en_q;
    assign downstream_reset = dn_rst_q;
    assign dev_speed        = speed_q;

endmodule
